lfsr_stream: RTL and testbench

Parametrised pseudo-random source and successor to the fixed 8-bit LFSR. Width, tap mask, default seed and structure (Fibonacci/Galois) are elaboration-time parameters. The seed is runtime-loadable. Output is a valid/ready stream, and the block measures the sequence period by detecting return to the loaded seed. It feeds test-pattern and random-replacement consumers in the core and the SoC bench.

---
 rtl/lfsr_stream.sv | 124 ++++++++++++
 tb/tb_lfsr_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised Fibonacci/Galois LFSR behind a valid/ready
// stream. It also measures the sequence period by watching for the state
// to return to the last loaded (reference) seed.
module lfsr_stream #(
  parameter int              WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
  parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit              GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // A tap on the top bit keeps the map invertible, so every state lies on
  // a cycle and the period detector always terminates.
  if ((WIDTH < 3) || (WIDTH > 32)) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be in 3..32");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_stream: TAPS[WIDTH-1] must be 1");
  end

  // One LFSR step in the selected structure.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (GALOIS) begin
      r = (s >> 1) ^ (s[0] ? TAPS : ZERO);
    end else begin
      r = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    return r;
  endfunction

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] ref_r;
  logic [WIDTH-1:0] cnt_r;
  logic             out_valid_r;
  logic             wrap_r;
  logic [WIDTH-1:0] period_r;
  logic             period_valid_r;

  logic [WIDTH-1:0] state_nxt_s;
  logic [WIDTH-1:0] ref_nxt_s;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             wrap_nxt_s;
  logic [WIDTH-1:0] period_nxt_s;
  logic             period_valid_nxt_s;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] load_s;
  logic             fire_s;

  assign fire_s = out_valid_r & out_ready;
  assign step_s = lfsr_next(state_r);
  // A zero seed would lock the LFSR, so it is replaced by the default.
  assign load_s = (seed == ZERO) ? SEED : seed;

  // Next-state selection: seed load beats a handshake, which beats idle.
  always_comb begin
    state_nxt_s        = state_r;
    ref_nxt_s          = ref_r;
    cnt_nxt_s          = cnt_r;
    wrap_nxt_s         = 1'b0;
    period_nxt_s       = period_r;
    period_valid_nxt_s = period_valid_r;
    if (seed_valid) begin
      state_nxt_s        = load_s;
      ref_nxt_s          = load_s;
      cnt_nxt_s          = ZERO;
      period_valid_nxt_s = 1'b0;
    end else if (fire_s) begin
      state_nxt_s = step_s;
      if (step_s == ref_r) begin
        wrap_nxt_s         = 1'b1;
        period_nxt_s       = cnt_r + ONE;
        period_valid_nxt_s = 1'b1;
        cnt_nxt_s          = ZERO;
      end else begin
        cnt_nxt_s = cnt_r + ONE;
      end
    end else begin
      wrap_nxt_s = 1'b0;
    end
  end

  // State, period bookkeeping and stream-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= SEED;
      ref_r          <= SEED;
      cnt_r          <= ZERO;
      out_valid_r    <= 1'b0;
      wrap_r         <= 1'b0;
      period_r       <= ZERO;
      period_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      ref_r          <= ref_nxt_s;
      cnt_r          <= cnt_nxt_s;
      out_valid_r    <= en & ~seed_valid;
      wrap_r         <= wrap_nxt_s;
      period_r       <= period_nxt_s;
      period_valid_r <= period_valid_nxt_s;
    end
  end

  assign out_data     = state_r;
  assign out_valid    = out_valid_r;
  assign wrap         = wrap_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: default Fibonacci instance, a Galois
// instance and a 4-bit non-maximal instance.
module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       reset;
  // default instance controls
  logic       en, seed_valid, out_ready;
  logic [7:0] seed;
  logic       out_valid, wrap, period_valid;
  logic [7:0] out_data, period;
  // shared controls for the Galois and 4-bit instances
  logic       en2, sv2, rdy2;
  logic [7:0] seed_g;
  logic [3:0] seed_w;
  logic       g_valid, g_wrap, g_pv;
  logic [7:0] g_data, g_period;
  logic       w_valid, w_wrap, w_pv;
  logic [3:0] w_data, w_period;

  int checks = 0;
  int errors = 0;
  int fires  = 0;
  logic [7:0] model;

  always #5 clk = ~clk;

  lfsr_stream dut (
    .clk(clk), .reset(reset), .en(en), .seed_valid(seed_valid), .seed(seed),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .wrap(wrap), .period(period), .period_valid(period_valid)
  );

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .GALOIS(1'b1)) dut_g (
    .clk(clk), .reset(reset), .en(en2), .seed_valid(sv2), .seed(seed_g),
    .out_ready(rdy2), .out_valid(g_valid), .out_data(g_data),
    .wrap(g_wrap), .period(g_period), .period_valid(g_pv)
  );

  lfsr_stream #(.WIDTH(4), .TAPS(4'hF), .SEED(4'h1), .GALOIS(1'b0)) dut_w (
    .clk(clk), .reset(reset), .en(en2), .seed_valid(sv2), .seed(seed_w),
    .out_ready(rdy2), .out_valid(w_valid), .out_data(w_data),
    .wrap(w_wrap), .period(w_period), .period_valid(w_pv)
  );

  // Reference 8-bit Fibonacci step with taps 7,5,4,3.
  function automatic logic [7:0] fib8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; seed_valid = 1'b0; out_ready = 1'b0; seed = 8'h00;
    en2 = 1'b0; sv2 = 1'b0; rdy2 = 1'b0; seed_g = 8'h00; seed_w = 4'h0;
    step(); step();
    checks++;
    if ({out_valid, out_data, wrap, period, period_valid} !== {1'b0, 8'h01, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h w=%b p=%h pv=%b exp v=0 d=01 w=0 p=00 pv=0",
               out_valid, out_data, wrap, period, period_valid);
    end
    checks++;
    if ({g_valid, g_data, w_valid, w_data} !== {1'b0, 8'h01, 1'b0, 4'h1}) begin
      errors++;
      $display("FAIL reset_state_aux got g=%b/%h w=%b/%h exp 0/01 0/1", g_valid, g_data, w_valid, w_data);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    en = 1'b1; out_ready = 1'b1;
    step();
    model = 8'h01;
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
        errors++;
        $display("FAIL fib_seq[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_seq[i]);
      end
      step();
      fires++;
      model = fib8(model);
    end
  endtask

  task automatic test_period();
    while (fires < 300) begin
      checks++;
      if (out_data !== model || wrap !== ((fires % 255) == 0)) begin
        errors++;
        $display("FAIL free_run fire %0d got d=%h w=%b exp d=%h w=%b",
                 fires, out_data, wrap, model, ((fires % 255) == 0));
      end
      if (fires == 254) begin
        checks++;
        if (period_valid !== 1'b0) begin
          errors++;
          $display("FAIL pv_before_wrap got %b exp 0", period_valid);
        end
      end
      if (fires == 255) begin
        checks++;
        if (out_data !== 8'h01) begin
          errors++;
          $display("FAIL wrap_state got %h exp 01", out_data);
        end
      end
      step();
      fires++;
      model = fib8(model);
    end
    checks++;
    if (period !== 8'hFF || period_valid !== 1'b1) begin
      errors++;
      $display("FAIL period got p=%h pv=%b exp p=ff pv=1", period, period_valid);
    end
  endtask

  task automatic test_stall_and_load();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_data !== model || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, model);
      end
    end
    seed_valid = 1'b1; seed = 8'h00; out_ready = 1'b1;
    step();
    seed_valid = 1'b0;
    checks++;
    if ({out_valid, out_data, period_valid, period, wrap} !== {1'b0, 8'h01, 1'b0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL zero_seed_load got v=%b d=%h pv=%b p=%h w=%b exp v=0 d=01 pv=0 p=ff w=0",
               out_valid, out_data, period_valid, period, wrap);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL after_load got v=%b d=%h exp v=1 d=01", out_valid, out_data);
    end
    // non-zero seed, then two steps from it
    seed_valid = 1'b1; seed = 8'h8E;
    step();
    seed_valid = 1'b0;
    model = 8'h8E;
    checks++;
    if (out_data !== 8'h8E || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL seed_load got v=%b d=%h exp v=0 d=8e", out_valid, out_data);
    end
    step();
    step();
    model = fib8(model);
    checks++;
    if (out_data !== model || out_data !== 8'h1C) begin
      errors++;
      $display("FAIL seed_step got %h exp 1c", out_data);
    end
  endtask

  task automatic test_galois_width4();
    logic [7:0] g_seq [6] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'h59};
    logic [3:0] w_seq [6] = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h1};
    g_seq[0] = 8'h01; g_seq[1] = 8'hB8; g_seq[2] = 8'h5C;
    g_seq[3] = 8'h2E; g_seq[4] = 8'h17; g_seq[5] = 8'hB3;
    en2 = 1'b1; rdy2 = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (g_valid !== 1'b1 || g_data !== g_seq[i]) begin
        errors++;
        $display("FAIL galois[%0d] got v=%b d=%h exp v=1 d=%h", i, g_valid, g_data, g_seq[i]);
      end
      checks++;
      if (w_data !== w_seq[i] || w_wrap !== (i == 5) || w_pv !== (i == 5)) begin
        errors++;
        $display("FAIL w4[%0d] got d=%h w=%b pv=%b exp d=%h w=%b pv=%b",
                 i, w_data, w_wrap, w_pv, w_seq[i], (i == 5), (i == 5));
      end
      step();
    end
    checks++;
    if (w_period !== 4'h5 || w_wrap !== 1'b0) begin
      errors++;
      $display("FAIL w4_period got p=%h w=%b exp p=5 w=0", w_period, w_wrap);
    end
    en2 = 1'b0;
  endtask

  task automatic test_async_reset();
    step();
    step();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, period_valid, period} !== {1'b0, 8'h01, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h pv=%b p=%h exp v=0 d=01 pv=0 p=00",
               out_valid, out_data, period_valid, period);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_period();
    test_stall_and_load();
    test_galois_width4();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
